// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit barrel shifter (SLL/SRL/SRA) between
// two requesters, each returning results through its own registered slot.
module shift_arbiter #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             iClk,
  input  logic             inRst,

  input  logic             iA_Valid,
  output logic             oA_Ready,
  input  logic [31:0]      iA_D,
  input  logic [4:0]       iA_Shamt,
  input  logic             iA_RightnLeft,
  input  logic             iA_ArithnLogic,
  input  logic [TAG_W-1:0] iA_Tag,
  output logic             oA_ResValid,
  input  logic             iA_ResReady,
  output logic [31:0]      oA_ResD,
  output logic [TAG_W-1:0] oA_ResTag,
  output logic [CNT_W-1:0] oA_GntCnt,

  input  logic             iB_Valid,
  output logic             oB_Ready,
  input  logic [31:0]      iB_D,
  input  logic [4:0]       iB_Shamt,
  input  logic             iB_RightnLeft,
  input  logic             iB_ArithnLogic,
  input  logic [TAG_W-1:0] iB_Tag,
  output logic             oB_ResValid,
  input  logic             iB_ResReady,
  output logic [31:0]      oB_ResD,
  output logic [TAG_W-1:0] oB_ResTag,
  output logic [CNT_W-1:0] oB_GntCnt
);

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Single shared shift unit; arithmetic only matters for right shifts.
  function automatic logic [31:0] barrel_shift(
    input logic [31:0] d,
    input logic [4:0]  shamt,
    input logic        right,
    input logic        arith
  );
    logic [31:0] res;
    if (right) begin
      if (arith) begin
        res = $signed(d) >>> shamt;
      end else begin
        res = d >> shamt;
      end
    end else begin
      res = d << shamt;
    end
    return res;
  endfunction

  logic             last_grant_r;
  logic             res_valid_a_r;
  logic [31:0]      res_d_a_r;
  logic [TAG_W-1:0] res_tag_a_r;
  logic [CNT_W-1:0] gnt_cnt_a_r;
  logic             res_valid_b_r;
  logic [31:0]      res_d_b_r;
  logic [TAG_W-1:0] res_tag_b_r;
  logic [CNT_W-1:0] gnt_cnt_b_r;

  logic             slot_free_a_s;
  logic             slot_free_b_s;
  logic             elig_a_s;
  logic             elig_b_s;
  logic             grant_a_s;
  logic             grant_b_s;
  logic [31:0]      op_d_s;
  logic [4:0]       op_shamt_s;
  logic             op_right_s;
  logic             op_arith_s;
  logic [TAG_W-1:0] op_tag_s;
  logic [31:0]      shift_res_s;

  // A slot being drained this cycle counts as free so it can be refilled without a bubble.
  assign slot_free_a_s = !res_valid_a_r || iA_ResReady;
  assign slot_free_b_s = !res_valid_b_r || iB_ResReady;
  assign elig_a_s      = iA_Valid && slot_free_a_s;
  assign elig_b_s      = iB_Valid && slot_free_b_s;

  // Round-robin grant: on contention the requester not granted last wins.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (!inRst) begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end else if (elig_a_s && elig_b_s) begin
      grant_a_s = (last_grant_r == LAST_B);
      grant_b_s = (last_grant_r == LAST_A);
    end else begin
      grant_a_s = elig_a_s;
      grant_b_s = elig_b_s;
    end
  end

  // Operand mux in front of the shared shifter, steered by the grant.
  always_comb begin
    op_d_s     = iA_D;
    op_shamt_s = iA_Shamt;
    op_right_s = iA_RightnLeft;
    op_arith_s = iA_ArithnLogic;
    op_tag_s   = iA_Tag;
    if (grant_b_s) begin
      op_d_s     = iB_D;
      op_shamt_s = iB_Shamt;
      op_right_s = iB_RightnLeft;
      op_arith_s = iB_ArithnLogic;
      op_tag_s   = iB_Tag;
    end else begin
      op_d_s     = iA_D;
      op_shamt_s = iA_Shamt;
      op_right_s = iA_RightnLeft;
      op_arith_s = iA_ArithnLogic;
      op_tag_s   = iA_Tag;
    end
  end

  assign shift_res_s = barrel_shift(op_d_s, op_shamt_s, op_right_s, op_arith_s);

  // Round-robin pointer; holds across idle cycles so fairness survives gaps.
  always_ff @(posedge iClk) begin
    if (!inRst) begin
      last_grant_r <= LAST_B;
    end else if (grant_a_s) begin
      last_grant_r <= LAST_A;
    end else if (grant_b_s) begin
      last_grant_r <= LAST_B;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Requester A result slot: load on grant, otherwise clear valid on drain.
  always_ff @(posedge iClk) begin
    if (!inRst) begin
      res_valid_a_r <= 1'b0;
      res_d_a_r     <= 32'h0000_0000;
      res_tag_a_r   <= {TAG_W{1'b0}};
    end else if (grant_a_s) begin
      res_valid_a_r <= 1'b1;
      res_d_a_r     <= shift_res_s;
      res_tag_a_r   <= op_tag_s;
    end else if (res_valid_a_r && iA_ResReady) begin
      res_valid_a_r <= 1'b0;
    end else begin
      res_valid_a_r <= res_valid_a_r;
    end
  end

  // Requester B result slot: load on grant, otherwise clear valid on drain.
  always_ff @(posedge iClk) begin
    if (!inRst) begin
      res_valid_b_r <= 1'b0;
      res_d_b_r     <= 32'h0000_0000;
      res_tag_b_r   <= {TAG_W{1'b0}};
    end else if (grant_b_s) begin
      res_valid_b_r <= 1'b1;
      res_d_b_r     <= shift_res_s;
      res_tag_b_r   <= op_tag_s;
    end else if (res_valid_b_r && iB_ResReady) begin
      res_valid_b_r <= 1'b0;
    end else begin
      res_valid_b_r <= res_valid_b_r;
    end
  end

  // Saturating grant counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge iClk) begin
    if (!inRst) begin
      gnt_cnt_a_r <= {CNT_W{1'b0}};
      gnt_cnt_b_r <= {CNT_W{1'b0}};
    end else begin
      if (grant_a_s && (gnt_cnt_a_r != CNT_MAX)) begin
        gnt_cnt_a_r <= gnt_cnt_a_r + CNT_ONE;
      end else begin
        gnt_cnt_a_r <= gnt_cnt_a_r;
      end
      if (grant_b_s && (gnt_cnt_b_r != CNT_MAX)) begin
        gnt_cnt_b_r <= gnt_cnt_b_r + CNT_ONE;
      end else begin
        gnt_cnt_b_r <= gnt_cnt_b_r;
      end
    end
  end

  assign oA_Ready    = grant_a_s;
  assign oB_Ready    = grant_b_s;
  assign oA_ResValid = res_valid_a_r;
  assign oA_ResD     = res_d_a_r;
  assign oA_ResTag   = res_tag_a_r;
  assign oA_GntCnt   = gnt_cnt_a_r;
  assign oB_ResValid = res_valid_b_r;
  assign oB_ResD     = res_d_b_r;
  assign oB_ResTag   = res_tag_b_r;
  assign oB_GntCnt   = gnt_cnt_b_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed tables, corner sequences and
// randomized traffic against a behavioural reference model.
module tb_shift_arbiter;
  localparam int TAG_W = 4;

  logic iClk = 1'b0;
  always #5 iClk = ~iClk;

  logic             rst_n;
  logic             a_valid, a_right, a_arith, a_rr;
  logic [31:0]      a_d;
  logic [4:0]       a_sh;
  logic [TAG_W-1:0] a_tag;
  logic             b_valid, b_right, b_arith, b_rr;
  logic [31:0]      b_d;
  logic [4:0]       b_sh;
  logic [TAG_W-1:0] b_tag;

  logic             a_ready, a_rv, b_ready, b_rv;
  logic [31:0]      a_res, b_res;
  logic [TAG_W-1:0] a_rtag, b_rtag;
  logic [3:0]       a_cnt, b_cnt;
  logic             a16_ready, a16_rv, b16_ready, b16_rv;
  logic [31:0]      a16_res, b16_res;
  logic [TAG_W-1:0] a16_rtag, b16_rtag;
  logic [15:0]      a16_cnt, b16_cnt;

  shift_arbiter #(.TAG_W(TAG_W), .CNT_W(4)) u_dut (
    .iClk(iClk), .inRst(rst_n),
    .iA_Valid(a_valid), .oA_Ready(a_ready), .iA_D(a_d), .iA_Shamt(a_sh),
    .iA_RightnLeft(a_right), .iA_ArithnLogic(a_arith), .iA_Tag(a_tag),
    .oA_ResValid(a_rv), .iA_ResReady(a_rr), .oA_ResD(a_res), .oA_ResTag(a_rtag),
    .oA_GntCnt(a_cnt),
    .iB_Valid(b_valid), .oB_Ready(b_ready), .iB_D(b_d), .iB_Shamt(b_sh),
    .iB_RightnLeft(b_right), .iB_ArithnLogic(b_arith), .iB_Tag(b_tag),
    .oB_ResValid(b_rv), .iB_ResReady(b_rr), .oB_ResD(b_res), .oB_ResTag(b_rtag),
    .oB_GntCnt(b_cnt)
  );

  shift_arbiter #(.TAG_W(TAG_W), .CNT_W(16)) u_dut16 (
    .iClk(iClk), .inRst(rst_n),
    .iA_Valid(a_valid), .oA_Ready(a16_ready), .iA_D(a_d), .iA_Shamt(a_sh),
    .iA_RightnLeft(a_right), .iA_ArithnLogic(a_arith), .iA_Tag(a_tag),
    .oA_ResValid(a16_rv), .iA_ResReady(a_rr), .oA_ResD(a16_res), .oA_ResTag(a16_rtag),
    .oA_GntCnt(a16_cnt),
    .iB_Valid(b_valid), .oB_Ready(b16_ready), .iB_D(b_d), .iB_Shamt(b_sh),
    .iB_RightnLeft(b_right), .iB_ArithnLogic(b_arith), .iB_Tag(b_tag),
    .oB_ResValid(b16_rv), .iB_ResReady(b_rr), .oB_ResD(b16_res), .oB_ResTag(b16_rtag),
    .oB_GntCnt(b16_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: result slots as plain values, grant counts as unbounded ints.
  bit               m_rv_a, m_rv_b, m_last_a;
  logic [31:0]      m_d_a, m_d_b;
  logic [TAG_W-1:0] m_tag_a, m_tag_b;
  int               m_cnt_a, m_cnt_b;
  bit               exp_ga, exp_gb;
  logic             act_ra, act_rb;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  sh;
    logic        right;
    logic        arith;
    logic [31:0] expect_d;
  } shift_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh,
                                            input bit right, input bit arith);
    longint unsigned p, v;
    p = 64'd1;
    for (int i = 0; i < sh; i++) p = p * 64'd2;
    v = {32'd0, d};
    if (!right) return 32'((v * p) % 64'h1_0000_0000);
    if (arith && d[31]) return ~32'((~v & 64'hFFFF_FFFF) / p);
    return 32'(v / p);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_side(input string s, input logic ready, input bit g,
                            input logic rv, input logic [31:0] d, input logic [TAG_W-1:0] tg,
                            input logic [3:0] c4, input logic ready16, input logic rv16,
                            input logic [31:0] d16, input logic [TAG_W-1:0] tg16,
                            input logic [15:0] c16, input bit mrv, input logic [31:0] md,
                            input logic [TAG_W-1:0] mtag, input int mcnt);
    chk({s, "_ready"}, ready, g);
    chk({s, "16_ready"}, ready16, g);
    chk({s, "_resvalid"}, rv, mrv);
    chk({s, "16_resvalid"}, rv16, mrv);
    if (mrv) begin
      chk({s, "_resd"}, d, md);
      chk({s, "16_resd"}, d16, md);
      chk({s, "_restag"}, tg, mtag);
      chk({s, "16_restag"}, tg16, mtag);
    end
    chk({s, "_gntcnt4"}, c4, sat(mcnt, 15));
    chk({s, "16_gntcnt"}, c16, sat(mcnt, 65535));
  endtask

  task automatic check_outputs();
    bit ea, eb;
    ea = rst_n && a_valid && (!m_rv_a || a_rr);
    eb = rst_n && b_valid && (!m_rv_b || b_rr);
    if (ea && eb) begin
      exp_ga = !m_last_a;
      exp_gb = m_last_a;
    end else begin
      exp_ga = ea;
      exp_gb = eb;
    end
    act_ra = a_ready;
    act_rb = b_ready;
    check_side("a", a_ready, exp_ga, a_rv, a_res, a_rtag, a_cnt, a16_ready, a16_rv,
               a16_res, a16_rtag, a16_cnt, m_rv_a, m_d_a, m_tag_a, m_cnt_a);
    check_side("b", b_ready, exp_gb, b_rv, b_res, b_rtag, b_cnt, b16_ready, b16_rv,
               b16_res, b16_rtag, b16_cnt, m_rv_b, m_d_b, m_tag_b, m_cnt_b);
  endtask

  task automatic update_model();
    if (!rst_n) begin
      m_rv_a = 0; m_rv_b = 0; m_d_a = 0; m_d_b = 0; m_tag_a = 0; m_tag_b = 0;
      m_cnt_a = 0; m_cnt_b = 0; m_last_a = 0;
    end else begin
      if (exp_ga) begin
        m_rv_a = 1; m_d_a = ref_shift(a_d, a_sh, a_right, a_arith); m_tag_a = a_tag;
        m_cnt_a++; m_last_a = 1;
      end else if (m_rv_a && a_rr) m_rv_a = 0;
      if (exp_gb) begin
        m_rv_b = 1; m_d_b = ref_shift(b_d, b_sh, b_right, b_arith); m_tag_b = b_tag;
        m_cnt_b++; m_last_a = 0;
      end else if (m_rv_b && b_rr) m_rv_b = 0;
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge iClk);
    check_outputs();
    @(posedge iClk);
    update_model();
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  task automatic set_a(input logic v, input logic [31:0] d, input logic [4:0] sh,
                       input logic r, input logic ar, input logic [TAG_W-1:0] t);
    a_valid = v; a_d = d; a_sh = sh; a_right = r; a_arith = ar; a_tag = t;
  endtask

  task automatic set_b(input logic v, input logic [31:0] d, input logic [4:0] sh,
                       input logic r, input logic ar, input logic [TAG_W-1:0] t);
    b_valid = v; b_d = d; b_sh = sh; b_right = r; b_arith = ar; b_tag = t;
  endtask

  shift_vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000};
    vecs[1] = '{32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001};
    vecs[2] = '{32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF};
    vecs[3] = '{32'h1234_5678, 5'd0,  1'b1, 1'b1, 32'h1234_5678};
    vecs[4] = '{32'h8000_0001, 5'd4,  1'b0, 1'b1, 32'h0000_0010};
    vecs[5] = '{32'hF000_0000, 5'd4,  1'b1, 1'b1, 32'hFF00_0000};
    vecs[6] = '{32'hF000_0000, 5'd4,  1'b1, 1'b0, 32'h0F00_0000};

    rst_n = 1'b0;
    set_a(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 4'd0);
    set_b(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 4'd0);
    a_rr = 1'b1;
    b_rr = 1'b1;
    @(posedge iClk);
    update_model();
    #1;
    do_reset(1);
    chk("reset_a_resvalid", a_rv, 1'b0);
    chk("reset_a_resd", a_res, 32'd0);
    chk("reset_b_restag", b_rtag, 4'd0);
    chk("reset_b_gntcnt", b16_cnt, 16'd0);

    // Single A request after reset.
    set_a(1'b1, 32'h8000_0001, 5'd4, 1'b1, 1'b1, 4'd3);
    cycle();
    chk("t1_a_ready", act_ra, 1'b1);
    a_valid = 1'b0;
    chk("t1_a_resvalid", a_rv, 1'b1);
    chk("t1_a_resd", a_res, 32'hF800_0000);
    chk("t1_a_restag", a_rtag, 4'd3);
    chk("t1_a_gntcnt", a16_cnt, 16'd1);
    chk("t1_b_resvalid", b_rv, 1'b0);
    chk("t1_b_gntcnt", b16_cnt, 16'd0);

    // Contention: strict alternation starting with A.
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      set_a(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 4'($urandom));
      set_b(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 4'($urandom));
      cycle();
      chk("t2_a_grant", act_ra, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("t2_b_grant", act_rb, (i % 2 == 1) ? 1'b1 : 1'b0);
    end
    chk("t2_a_gntcnt", a16_cnt, 16'd5);
    chk("t2_b_gntcnt", b16_cnt, 16'd5);

    // Backpressure on A: held result stays put, B runs every cycle, no bubble on release.
    a_rr = 1'b0;
    set_a(1'b1, 32'h0000_00F0, 5'd4, 1'b0, 1'b0, 4'd5);
    cycle();
    chk("t3_a_first_grant", act_ra, 1'b1);
    set_a(1'b1, 32'h0000_DEAD, 5'd1, 1'b1, 1'b0, 4'd9);
    for (int i = 0; i < 4; i++) begin
      set_b(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 4'($urandom));
      cycle();
      chk("t3_a_blocked", act_ra, 1'b0);
      chk("t3_b_granted", act_rb, 1'b1);
      chk("t3_a_hold_d", a_res, 32'h0000_0F00);
      chk("t3_a_hold_tag", a_rtag, 4'd5);
    end
    a_rr = 1'b1;
    set_a(1'b1, 32'h0000_0001, 5'd1, 1'b0, 1'b0, 4'd6);
    cycle();
    chk("t3_a_refill_grant", act_ra, 1'b1);
    chk("t3_a_refill_valid", a_rv, 1'b1);
    chk("t3_a_refill_d", a_res, 32'h0000_0002);
    chk("t3_a_refill_tag", a_rtag, 4'd6);

    // Boundary shifts through B alone.
    a_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_b(1'b1, vecs[i].d, vecs[i].sh, vecs[i].right, vecs[i].arith, 4'(i));
      cycle();
      chk($sformatf("t4_vec%0d_grant", i), act_rb, 1'b1);
      chk($sformatf("t4_vec%0d_resd", i), b_res, vecs[i].expect_d);
    end

    // Reset while both slots hold results.
    a_rr = 1'b0;
    b_rr = 1'b0;
    set_a(1'b1, 32'h1111_1111, 5'd2, 1'b0, 1'b0, 4'd1);
    set_b(1'b1, 32'h2222_2222, 5'd2, 1'b1, 1'b0, 4'd2);
    cycle();
    cycle();
    chk("t5_a_full", a_rv, 1'b1);
    chk("t5_b_full", b_rv, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t5_a_resvalid", a_rv, 1'b0);
    chk("t5_b_resvalid", b_rv, 1'b0);
    chk("t5_a_resd", a_res, 32'd0);
    chk("t5_b_resd", b_res, 32'd0);
    chk("t5_a_gntcnt", a16_cnt, 16'd0);
    chk("t5_b_gntcnt", b16_cnt, 16'd0);
    a_rr = 1'b1;
    b_rr = 1'b1;
    cycle();
    chk("t5_first_grant_a", act_ra, 1'b1);
    chk("t5_first_grant_b", act_rb, 1'b0);

    // Counter saturation with the 4-bit instance.
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      set_a(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 4'($urandom));
      cycle();
    end
    a_valid = 1'b0;
    chk("t6_cnt4_sat", a_cnt, 4'hF);
    chk("t6_cnt16", a16_cnt, 16'd20);
    chk("t6_resvalid", a_rv, 1'b1);

    // Randomized traffic with occasional resets and backpressure.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      set_a(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
            1'($urandom), 1'($urandom), 4'($urandom));
      set_b(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
            1'($urandom), 1'($urandom), 4'($urandom));
      a_rr = ($urandom_range(0, 9) < 7);
      b_rr = ($urandom_range(0, 9) < 6);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Two-requester arbiter and sequencer for a single shared 32-bit barrel shift datapath (SLL/SRL/SRA). It accepts shift operations from two independent requesters, A and B, over valid/ready channels and grants at most one per cycle using round-robin. It runs the granted operation through one internal shift unit and returns the registered result on that requester's own result channel. It sits between the issue stage and writeback wherever two sources (e.g. integer pipe and address/CSR pipe) must share one shifter.

Parameters:
TAG_W, 4, width of the opaque tag carried from request to result
CNT_W, 16, width of the per-requester saturating grant counters

Ports:
iClk  input  1  clock, all state updates on rising edge
inRst  input  1  synchronous active-low reset
iA_Valid  input  1  requester A operation valid
oA_Ready  output  1  A operation accepted this cycle (grant)
iA_D  input  32  A operand
iA_Shamt  input  5  A shift amount
iA_RightnLeft  input  1  A: 1 = right, 0 = left
iA_ArithnLogic  input  1  A: 1 = arithmetic, 0 = logical (right shifts only)
iA_Tag  input  TAG_W  A request tag
oA_ResValid  output  1  A result valid
iA_ResReady  input  1  A result consumer ready
oA_ResD  output  32  A shift result
oA_ResTag  output  TAG_W  tag of the A result
oA_GntCnt  output  CNT_W  saturating count of A grants
(iB_*/oB_* ports: identical set to A, with all A-prefixed names replaced by B)

Behaviour:
- Reset: synchronous active-low, single clock, sampled on the iClk rising edge.
  - While inRst=0 at an edge: oX_ResValid=0, oX_ResD=0, oX_ResTag=0, oX_GntCnt=0, lastGrant=B (so A wins the first tie).
  - oX_Ready is 0 during reset.
  - Reset mid-operation discards any held results without handshake.
- Slot free: slotFree_X = !oX_ResValid | iX_ResReady. A result slot freed by a drain may be refilled in the same cycle.
- Eligibility: elig_X = iX_Valid & slotFree_X.
- Grant (combinational, at most one per cycle):
  - Only one requester eligible: grant it.
  - Both eligible: grant the requester != lastGrant.
  - Neither eligible: no grant.
  - oX_Ready = grant_X. A transfer occurs when iX_Valid & oX_Ready.
  - oX_Ready depends on iX_Valid. Requesters must not make iX_Valid depend on oX_Ready.
- lastGrant updates only on a grant. Its value holds across idle cycles.
- Datapath: one shift unit. Its inputs are muxed from the granted requester.
  - Right & Arith = SRA, sign-filled.
  - Right & !Arith = SRL, zero-filled.
  - Left = SLL, zero-filled; ArithnLogic is ignored for left shifts.
  - Shift amount is 0..31; shamt 0 passes the operand through.
- Latency: one cycle. The result is registered into the granted slot at the grant edge. oX_ResValid=1 from the next cycle, with oX_ResD and oX_ResTag.
- Result hold: oX_ResD and oX_ResTag stay stable while oX_ResValid=1 & iX_ResReady=0.
- Result slot update at each edge:
  - grant_X: load the new result, ResValid=1.
  - Else if ResValid & ResReady: ResValid=0. Data may hold its stale value.
  - Else: hold.
- Throughput: one shift per cycle total. Each requester sustains 1/cycle alone, or 1/2 cycles under contention.
- A blocked requester (slot full) never stalls the other. The other is granted every cycle it is eligible.
- Counters: oX_GntCnt increments on each grant_X and saturates at all-ones (no wrap).

Test Plan:
1. After reset, A only: iA_D=0x8000_0001, Shamt=4, Right=1, Arith=1, Tag=3; A consumer ready.
   -> oA_Ready=1 that cycle; next cycle oA_ResValid=1, oA_ResD=0xF800_0000, oA_ResTag=3, oA_GntCnt=1; B outputs unchanged (0).
2. A and B both valid every cycle for 10 cycles, both consumers ready.
   -> Grants A,B,A,B,... starting with A; each result appears one cycle after its grant; oA_GntCnt=5, oB_GntCnt=5.
3. Backpressure: iA_ResReady=0 with an A result held; A and B both valid.
   -> oA_Ready=0 and A result data/tag stable; B granted every cycle; when iA_ResReady rises, A is granted in that same cycle and the slot is refilled with no bubble (ResValid stays 1, data updates).
4. Boundary shifts via B:
   -> SLL 0x0000_0001 by 31 = 0x8000_0000
   -> SRL 0x8000_0000 by 31 = 0x0000_0001
   -> SRA 0x8000_0000 by 31 = 0xFFFF_FFFF
   -> shamt 0 with operand 0x1234_5678 returns 0x1234_5678
   -> left shift with Arith=1 behaves as SLL
5. Mid-operation reset: inRst=0 for one edge while oA_ResValid=1 and oB_ResValid=1.
   -> Next cycle all ResValid=0, ResD=0, GntCnt=0; with both valid afterwards, the first grant goes to A.
6. CNT_W=4, A alone valid for 20 cycles, consumer ready.
   -> oA_GntCnt reaches 0xF and stays 0xF; grants and results continue normally.
